// File: rtl/route_sel_ctrl_pkg.sv
// Shared types and constants for the route select controller.
package route_sel_ctrl_pkg;

  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    StOff = 1'b0,
    StOn  = 1'b1
  } en_state_e;

endpackage

// File: rtl/route_sel_ctrl_btn_debounce.sv
// Button conditioner: synchronizer, consecutive-cycle debouncer and registered
// single-cycle press pulse on the debounced rising level.
module btn_debounce #(
  parameter int unsigned DB_COUNT    = 1000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned     CntW    = $clog2(DB_COUNT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DB_COUNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   level_prev_q;
  logic                   press_q;

  assign btn_s = sync_q[SYNC_STAGES-1];

  // Count only while the synchronized input disagrees; any agreeing cycle restarts.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (btn_s != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], btn};
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/route_sel_ctrl.sv
// Push-button controller for the nibble mux/demux: source and destination
// group selects stepped up/down by buttons, plus a toggled route enable.
module route_sel_ctrl
  import route_sel_ctrl_pkg::*;
#(
  parameter int unsigned DB_COUNT    = 1000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btnl,
  input  logic             btnu,
  input  logic             btnr,
  input  logic             btnd,
  input  logic             btnc,
  output logic [SEL_W-1:0] mux_sel,
  output logic [SEL_W-1:0] demux_sel,
  output logic             enable
);

  // Bit order: 0=l, 1=u, 2=r, 3=d, 4=c
  logic [4:0] btn_raw;
  logic [4:0] press;

  logic [SEL_W-1:0] mux_q, mux_d;
  logic [SEL_W-1:0] demux_q, demux_d;
  en_state_e        state_q, state_d;

  assign btn_raw = {btnc, btnd, btnr, btnu, btnl};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_debounce #(
      .DB_COUNT   (DB_COUNT),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_btn_debounce (
      .clk  (clk),
      .reset(reset),
      .btn  (btn_raw[i]),
      .press(press[i])
    );
  end

  // Opposing steps in the same cycle cancel; selects update regardless of enable.
  always_comb begin
    mux_d   = mux_q;
    demux_d = demux_q;
    case ({press[0], press[1]})
      2'b10:   mux_d = mux_q + SEL_W'(1);
      2'b01:   mux_d = mux_q - SEL_W'(1);
      default: mux_d = mux_q;
    endcase
    case ({press[2], press[3]})
      2'b10:   demux_d = demux_q + SEL_W'(1);
      2'b01:   demux_d = demux_q - SEL_W'(1);
      default: demux_d = demux_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (press[4]) begin
      state_d = (state_q == StOff) ? StOn : StOff;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mux_q   <= '0;
      demux_q <= '0;
      state_q <= StOff;
    end else begin
      mux_q   <= mux_d;
      demux_q <= demux_d;
      state_q <= state_d;
    end
  end

  assign mux_sel   = mux_q;
  assign demux_sel = demux_q;
  assign enable    = (state_q == StOn);

endmodule

// File: tb/tb_route_sel_ctrl.sv
// Scoreboard bench for route_sel_ctrl with DB_COUNT=4 (press-to-output latency 7 edges).
module tb_route_sel_ctrl;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  mux;
    logic [1:0]  demux;
    logic        en;
  } exp_t;

  localparam int unsigned Lat = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btnl = 1'b0, btnu = 1'b0, btnr = 1'b0, btnd = 1'b0, btnc = 1'b0;
  logic [1:0] mux_sel, demux_sel;
  logic       enable;

  exp_t        q[$];
  exp_t        cur;
  int unsigned cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  bit          chk_en = 1'b0;

  route_sel_ctrl #(
    .DB_COUNT   (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btnl     (btnl),
    .btnu     (btnu),
    .btnr     (btnr),
    .btnd     (btnd),
    .btnc     (btnc),
    .mux_sel  (mux_sel),
    .demux_sel(demux_sel),
    .enable   (enable)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: retire expected changes due by this edge, compare every cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) cur = q.pop_front();
    if (chk_en) begin
      compared++;
      if (mux_sel !== cur.mux || demux_sel !== cur.demux || enable !== cur.en) begin
        mismatched++;
        $display("FAIL outputs @edge %0d: got mux_sel=%0d demux_sel=%0d enable=%0b, expected %0d %0d %0b",
                 cyc, mux_sel, demux_sel, enable, cur.mux, cur.demux, cur.en);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [4:0] m);
    {btnc, btnd, btnr, btnu, btnl} = m;
  endtask

  task automatic push(input int unsigned at, input logic [1:0] m, input logic [1:0] d,
                      input logic e);
    exp_t x;
    x.cyc   = at;
    x.mux   = m;
    x.demux = d;
    x.en    = e;
    q.push_back(x);
  endtask

  // Hold mask for 10 cycles; outputs take the given values Lat edges after first sample.
  task automatic press(input logic [4:0] m, input logic [1:0] em, input logic [1:0] ed,
                       input logic ee);
    push(cyc + 1 + Lat, em, ed, ee);
    set_btns(m);
    step(10);
    set_btns(5'b0);
    step(12);
  endtask

  task automatic do_reset();
    push(cyc + 1, 2'd0, 2'd0, 1'b0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    int unsigned base;
    cur.cyc = 0; cur.mux = 2'd0; cur.demux = 2'd0; cur.en = 1'b0;
    step(2);
    chk_en = 1'b1;
    reset  = 1'b0;
    step(20);

    // Mask order {c,d,r,u,l}
    press(5'b00001, 2'd1, 2'd0, 1'b0);
    press(5'b00001, 2'd2, 2'd0, 1'b0);
    press(5'b00001, 2'd3, 2'd0, 1'b0);
    press(5'b00001, 2'd0, 2'd0, 1'b0);
    press(5'b00010, 2'd3, 2'd0, 1'b0);
    press(5'b01000, 2'd3, 2'd3, 1'b0);

    // Bounces shorter than the debounce window must not toggle enable
    for (int i = 0; i < 5; i++) begin
      btnc = 1'b1; step(3);
      btnc = 1'b0; step(3);
    end
    press(5'b10000, 2'd3, 2'd3, 1'b1);
    press(5'b00100, 2'd3, 2'd0, 1'b1);
    press(5'b00010, 2'd2, 2'd0, 1'b1);
    press(5'b10000, 2'd2, 2'd0, 1'b0);

    do_reset();
    step(5);
    press(5'b01100, 2'd0, 2'd0, 1'b0);
    press(5'b00101, 2'd1, 2'd1, 1'b0);
    press(5'b00011, 2'd1, 2'd1, 1'b0);
    press(5'b10000, 2'd1, 2'd1, 1'b1);

    // btnc held across a one-cycle reset at edge base+3; fresh press counted from base+4
    base = cyc + 1;
    push(base + 3, 2'd0, 2'd0, 1'b0);
    push(base + 4 + Lat, 2'd0, 2'd0, 1'b1);
    btnc = 1'b1;
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(40);
    btnc = 1'b0;
    step(12);

    step(5);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard drain: got %0d pending entries, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
